// File: rtl/moving_average_mc.sv
// Multichannel moving-average filter: per-channel block (decimating) or sliding-window
// average over N = 2^log2_n samples, with optional divide-by-N or saturating raw sum.
module moving_average_mc #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_CH     = 2,
  parameter int MAX_LOG2_N = 6,
  parameter int SIGNED     = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cfg_log2_n,
  input  logic                  cfg_mode,
  input  logic                  cfg_scale,
  input  logic                  cfg_update,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [CH_W-1:0]       s_chan,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic [CH_W-1:0]       m_chan,
  output logic                  sat_flag,
  output logic                  chan_err
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_N;
  localparam int DEPTH = 1 << MAX_LOG2_N;
  localparam int CNT_W = MAX_LOG2_N + 1;
  localparam int WW    = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;

  localparam logic [CH_W:0]          NUM_CH_V = (CH_W + 1)'(NUM_CH);
  localparam logic [3:0]             MAX_LG   = 4'(MAX_LOG2_N);
  localparam logic [CNT_W-1:0]       CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic signed [WW-1:0]   ONE      = {{(WW - 1){1'b0}}, 1'b1};
  localparam logic signed [WW-1:0]   HI_LIM   = (SIGNED != 0) ? (ONE <<< (OUT_WIDTH - 1)) - ONE
                                                              : (ONE <<< OUT_WIDTH) - ONE;
  localparam logic signed [WW-1:0]   LO_LIM   = (SIGNED != 0) ? -(ONE <<< (OUT_WIDTH - 1)) : '0;

  logic [3:0]            log2_n_q, log2_n_d;
  logic                  mode_q, mode_d;
  logic                  scale_q, scale_d;
  logic [ACC_W-1:0]      acc_q [NUM_CH];
  logic [ACC_W-1:0]      acc_d [NUM_CH];
  logic [CNT_W-1:0]      cnt_q [NUM_CH];
  logic [CNT_W-1:0]      cnt_d [NUM_CH];
  logic [MAX_LOG2_N-1:0] wp_q  [NUM_CH];
  logic [MAX_LOG2_N-1:0] wp_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] ring_q [NUM_CH][DEPTH];
  logic                  m_valid_q, m_valid_d;
  logic [OUT_WIDTH-1:0]  m_data_q, m_data_d;
  logic [CH_W-1:0]       m_chan_q, m_chan_d;
  logic                  sat_q, sat_d;
  logic                  chan_err_q, chan_err_d;

  logic                  accept, chan_ok, full, due, ring_we, clamp_hi, clamp_lo;
  logic [CH_W-1:0]       ch;
  logic [CNT_W-1:0]      n_val, fill_new;
  logic [MAX_LOG2_N-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] old_raw;
  logic [ACC_W-1:0]      x_ext, old_ext, sum_new;
  logic signed [WW-1:0]  s_w, sel;
  logic [OUT_WIDTH-1:0]  f_out;

  // Handshake: a sample transfers on s_valid && s_ready; the result is held in one output
  // register until m_valid && m_ready, and s_ready never looks at s_valid.
  assign s_ready  = !cfg_update && (!m_valid_q || m_ready);
  assign accept   = s_valid && s_ready;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_chan   = m_chan_q;
  assign sat_flag = sat_q;
  assign chan_err = chan_err_q;

  always_comb begin
    log2_n_d   = log2_n_q;
    mode_d     = mode_q;
    scale_d    = scale_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    wp_d       = wp_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_chan_d   = m_chan_q;
    sat_d      = sat_q;
    chan_err_d = chan_err_q;
    ring_we    = 1'b0;

    chan_ok = ({1'b0, s_chan} < NUM_CH_V);
    ch      = chan_ok ? s_chan : '0;
    n_val   = CNT_ONE << log2_n_q;
    x_ext   = {{MAX_LOG2_N{(SIGNED != 0) && s_data[DATA_WIDTH-1]}}, s_data};
    // cnt doubles as the block counter and the sliding fill level.
    full    = (cnt_q[ch] == n_val);
    rd_ptr  = wp_q[ch] - n_val[MAX_LOG2_N-1:0];
    old_raw = ring_q[ch][rd_ptr];
    old_ext = '0;
    if (mode_q && full) old_ext = {{MAX_LOG2_N{(SIGNED != 0) && old_raw[DATA_WIDTH-1]}}, old_raw};

    sum_new  = acc_q[ch] + x_ext - old_ext;
    fill_new = (mode_q && full) ? n_val : cnt_q[ch] + CNT_ONE;
    due      = (fill_new == n_val);

    s_w      = {{(WW - ACC_W){(SIGNED != 0) && sum_new[ACC_W-1]}}, sum_new};
    sel      = scale_q ? (s_w >>> log2_n_q) : s_w;
    clamp_hi = (sel > HI_LIM);
    clamp_lo = (sel < LO_LIM);
    f_out    = clamp_hi ? HI_LIM[OUT_WIDTH-1:0] : (clamp_lo ? LO_LIM[OUT_WIDTH-1:0] : sel[OUT_WIDTH-1:0]);

    if (m_ready) m_valid_d = 1'b0;

    if (accept) begin
      if (!chan_ok) begin
        chan_err_d = 1'b1;
      end else begin
        if (mode_q) begin
          acc_d[ch] = sum_new;
          cnt_d[ch] = fill_new;
          wp_d[ch]  = wp_q[ch] + 1'b1;
          ring_we   = 1'b1;
        end else if (due) begin
          acc_d[ch] = '0;
          cnt_d[ch] = '0;
        end else begin
          acc_d[ch] = sum_new;
          cnt_d[ch] = fill_new;
        end
        if (due) begin
          m_valid_d = 1'b1;
          m_chan_d  = ch;
          m_data_d  = f_out;
          if (clamp_hi || clamp_lo) sat_d = 1'b1;
        end
      end
    end

    // A pending output survives a config update; only the filter state is flushed.
    if (cfg_update) begin
      log2_n_d   = (cfg_log2_n > MAX_LG) ? MAX_LG : cfg_log2_n;
      mode_d     = cfg_mode;
      scale_d    = cfg_scale;
      sat_d      = 1'b0;
      chan_err_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
        wp_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      log2_n_q   <= '0;
      mode_q     <= 1'b0;
      scale_q    <= 1'b1;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_chan_q   <= '0;
      sat_q      <= 1'b0;
      chan_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        wp_q[i]  <= '0;
      end
    end else begin
      log2_n_q   <= log2_n_d;
      mode_q     <= mode_d;
      scale_q    <= scale_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_chan_q   <= m_chan_d;
      sat_q      <= sat_d;
      chan_err_q <= chan_err_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
    end
  end

  // Ring contents need no reset: an entry is only read once the fill level proves it written.
  always_ff @(posedge clk) begin
    if (ring_we) ring_q[ch][wp_q[ch]] <= s_data;
  end

endmodule

// File: tb/tb_moving_average_mc.sv
// Bench for moving_average_mc: unsigned and signed instances share one stimulus stream and
// are checked every cycle against a sample-history reference model.
module tb_moving_average_mc;

  localparam int DW  = 12;
  localparam int OW  = 16;
  localparam int NCH = 3;
  localparam int CHW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      cfg_log2_n = '0;
  logic            cfg_mode = 1'b0;
  logic            cfg_scale = 1'b1;
  logic            cfg_update = 1'b0;
  logic            s_valid = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic [CHW-1:0]  s_chan = '0;
  logic            m_ready;
  logic            dir_rdy = 1'b1;
  logic            rnd_rdy = 1'b1;
  logic            rand_rdy = 1'b0;

  logic            s_ready_u, m_valid_u, sat_u, cerr_u;
  logic [OW-1:0]   m_data_u;
  logic [CHW-1:0]  m_chan_u;
  logic            s_ready_s, m_valid_s, sat_s, cerr_s;
  logic [OW-1:0]   m_data_s;
  logic [CHW-1:0]  m_chan_s;

  int n_checks = 0;
  int n_pass   = 0;

  logic [OW+CHW-1:0] exp_u_q[$];
  logic [OW+CHW-1:0] exp_s_q[$];
  logic [OW+CHW-1:0] got_u_q[$];
  logic [OW+CHW-1:0] got_s_q[$];

  logic [DW-1:0] hist [NCH][4096];
  int            hlen [NCH];
  int            m_lg;
  bit            m_mode, m_scale;
  bit            sat_m_u, sat_m_s, cerr_m;

  always #5 clk = ~clk;
  assign m_ready = rand_rdy ? rnd_rdy : dir_rdy;
  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  moving_average_mc #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_CH(NCH), .MAX_LOG2_N(6), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .cfg_log2_n(cfg_log2_n), .cfg_mode(cfg_mode), .cfg_scale(cfg_scale),
    .cfg_update(cfg_update), .s_valid(s_valid), .s_ready(s_ready_u), .s_data(s_data),
    .s_chan(s_chan), .m_valid(m_valid_u), .m_ready(m_ready), .m_data(m_data_u),
    .m_chan(m_chan_u), .sat_flag(sat_u), .chan_err(cerr_u));

  moving_average_mc #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_CH(NCH), .MAX_LOG2_N(6), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .cfg_log2_n(cfg_log2_n), .cfg_mode(cfg_mode), .cfg_scale(cfg_scale),
    .cfg_update(cfg_update), .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
    .s_chan(s_chan), .m_valid(m_valid_s), .m_ready(m_ready), .m_data(m_data_s),
    .m_chan(m_chan_s), .sat_flag(sat_s), .chan_err(cerr_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: the result is f(sum of the last N accepted samples of the channel) whenever
  // a full window exists (sliding) or a fresh block of N has just completed (block).
  function automatic void model_eval(input bit sgn, input int ch, output logic [OW-1:0] dat,
                                     output bit hit);
    longint sum, r, lo, hi;
    int n;
    n   = 1 << m_lg;
    sum = 0;
    for (int k = hlen[ch] - n; k < hlen[ch]; k++) begin
      if (sgn) sum += longint'($signed(hist[ch][k]));
      else     sum += longint'(hist[ch][k]);
    end
    hit = 1'b0;
    if (m_scale) begin
      r = sum >>> m_lg;
    end else begin
      lo = sgn ? -32768 : 0;
      hi = sgn ? 32767 : 65535;
      r  = sum;
      if (sum > hi) begin r = hi; hit = 1'b1; end
      else if (sum < lo) begin r = lo; hit = 1'b1; end
    end
    dat = r[OW-1:0];
  endfunction

  function automatic void model_accept(input int ch, input logic [DW-1:0] d);
    logic [OW-1:0] du, ds;
    bit hu, hs, fire;
    int n;
    if (ch >= NCH) begin
      cerr_m = 1'b1;
      return;
    end
    hist[ch][hlen[ch]] = d;
    hlen[ch]++;
    n    = 1 << m_lg;
    fire = m_mode ? (hlen[ch] >= n) : (hlen[ch] % n == 0);
    if (fire) begin
      model_eval(1'b0, ch, du, hu);
      model_eval(1'b1, ch, ds, hs);
      exp_u_q.push_back({CHW'(ch), du});
      exp_s_q.push_back({CHW'(ch), ds});
      if (hu) sat_m_u = 1'b1;
      if (hs) sat_m_s = 1'b1;
    end
  endfunction

  function automatic void model_flush(input int lg, input bit mode, input bit scale);
    for (int c = 0; c < NCH; c++) hlen[c] = 0;
    sat_m_u = 1'b0;
    sat_m_s = 1'b0;
    cerr_m  = 1'b0;
    m_lg    = (lg > 6) ? 6 : lg;
    m_mode  = mode;
    m_scale = scale;
  endfunction

  task automatic check_inst(input string p, input logic mv, input logic [OW-1:0] md,
                            input logic [CHW-1:0] mc, input logic sr, input logic sf,
                            input logic ce, input int qn, input logic [OW+CHW-1:0] fr,
                            input bit sat_e);
    chk({p, "_m_valid"}, 32'(mv), 32'(qn != 0));
    if (qn != 0) begin
      chk({p, "_m_data"}, 32'(md), 32'(fr[OW-1:0]));
      chk({p, "_m_chan"}, 32'(mc), 32'(fr[OW+CHW-1:OW]));
    end
    chk({p, "_s_ready"}, 32'(sr), 32'(!cfg_update && (qn == 0 || m_ready)));
    chk({p, "_sat_flag"}, 32'(sf), 32'(sat_e));
    chk({p, "_chan_err"}, 32'(ce), 32'(cerr_m));
  endtask

  // Per-cycle monitor, sampled mid-cycle: compare, then retire transfers, then log accepts.
  always @(negedge clk) begin
    logic [OW+CHW-1:0] fu, fs;
    if (!rst) begin
      chk("rst_m_valid", 32'(m_valid_u | m_valid_s), 32'd0);
      chk("rst_m_data", 32'(m_data_u | m_data_s), 32'd0);
      chk("rst_m_chan", 32'(m_chan_u | m_chan_s), 32'd0);
      chk("rst_flags", 32'({sat_u, sat_s, cerr_u, cerr_s}), 32'd0);
      model_flush(0, 1'b0, 1'b1);
      exp_u_q.delete();
      exp_s_q.delete();
    end else begin
      fu = (exp_u_q.size() != 0) ? exp_u_q[0] : '0;
      fs = (exp_s_q.size() != 0) ? exp_s_q[0] : '0;
      check_inst("u", m_valid_u, m_data_u, m_chan_u, s_ready_u, sat_u, cerr_u, exp_u_q.size(), fu, sat_m_u);
      check_inst("s", m_valid_s, m_data_s, m_chan_s, s_ready_s, sat_s, cerr_s, exp_s_q.size(), fs, sat_m_s);
      if (m_valid_u && m_ready) got_u_q.push_back({m_chan_u, m_data_u});
      if (m_valid_s && m_ready) got_s_q.push_back({m_chan_s, m_data_s});
      if (m_ready && exp_u_q.size() != 0) void'(exp_u_q.pop_front());
      if (m_ready && exp_s_q.size() != 0) void'(exp_s_q.pop_front());
      if (s_valid && s_ready_u) model_accept(int'(s_chan), s_data);
      if (cfg_update) model_flush(int'(cfg_log2_n), cfg_mode, cfg_scale);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int lg, input bit mode, input bit scale);
    cfg_log2_n = 4'(lg);
    cfg_mode   = mode;
    cfg_scale  = scale;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  task automatic send(input int ch, input int d);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    s_valid = 1'b1;
    s_chan  = CHW'(ch);
    s_data  = DW'(d);
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = s_ready_u;
      tick();
      t++;
    end
    s_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_u_q.size() != 0 || exp_s_q.size() != 0) && t < 200) begin
      tick();
      t++;
    end
    chk("drain", exp_u_q.size() + exp_s_q.size(), 32'd0);
    tick();
  endtask

  task automatic clear_got();
    got_u_q.delete();
    got_s_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Block N=4, divide: two outputs per eight samples.
    configure(2, 1'b0, 1'b1);
    clear_got();
    send(0, 10); send(0, 20); send(0, 30); send(0, 40);
    send(0, 1);  send(0, 2);  send(0, 3);  send(0, 6);
    drain();
    chk("blk_count", got_u_q.size(), 32'd2);
    chk("blk_first", 32'(got_u_q[0]), 32'({2'd0, 16'd25}));
    chk("blk_second", 32'(got_u_q[1]), 32'({2'd0, 16'd3}));
    chk("blk_signed", 32'(got_s_q[0]), 32'({2'd0, 16'd25}));

    // Sliding N=2 on channel 1: floor division of signed sums.
    configure(1, 1'b1, 1'b1);
    clear_got();
    send(1, 12'hFFC); send(1, 6); send(1, 10); send(1, 12'hFF6);
    drain();
    chk("sld_count", got_s_q.size(), 32'd3);
    chk("sld_a", 32'(got_s_q[0]), 32'({2'd1, 16'd1}));
    chk("sld_b", 32'(got_s_q[1]), 32'({2'd1, 16'd8}));
    chk("sld_c", 32'(got_s_q[2]), 32'({2'd1, 16'd0}));
    chk("sld_unsigned", 32'(got_u_q[0]), 32'({2'd1, 16'd2049}));

    // Interleaved block N=2.
    configure(1, 1'b0, 1'b1);
    clear_got();
    send(0, 100); send(1, 7); send(0, 200); send(1, 9);
    drain();
    chk("ilv_count", got_u_q.size(), 32'd2);
    chk("ilv_ch0", 32'(got_u_q[0]), 32'({2'd0, 16'd150}));
    chk("ilv_ch1", 32'(got_u_q[1]), 32'({2'd1, 16'd8}));

    // Raw sum saturation at N=64, then clear via config update.
    configure(6, 1'b0, 1'b0);
    clear_got();
    repeat (64) send(0, 12'hFFF);
    drain();
    @(negedge clk);
    chk("sat_u_data", 32'(got_u_q[0]), 32'({2'd0, 16'hFFFF}));
    chk("sat_u_flag", 32'(sat_u), 32'd1);
    chk("sat_s_data", 32'(got_s_q[0]), 32'({2'd0, 16'hFFC0}));
    chk("sat_s_flag", 32'(sat_s), 32'd0);
    tick();
    configure(0, 1'b0, 1'b1);
    @(negedge clk);
    chk("sat_cleared", 32'(sat_u), 32'd0);
    tick();

    // Backpressure with a pass-through window.
    clear_got();
    dir_rdy = 1'b0;
    s_valid = 1'b1;
    s_chan  = 2'd0;
    s_data  = 12'd123;
    tick();
    s_data  = 12'd456;
    repeat (5) begin
      @(negedge clk);
      chk("bp_s_ready", 32'(s_ready_u), 32'd0);
      chk("bp_m_data", 32'(m_data_u), 32'd123);
      tick();
    end
    dir_rdy = 1'b1;
    send(0, 456);
    drain();
    chk("bp_count", got_u_q.size(), 32'd2);
    chk("bp_first", 32'(got_u_q[0]), 32'({2'd0, 16'd123}));
    chk("bp_second", 32'(got_u_q[1]), 32'({2'd0, 16'd456}));

    // Reset mid-window with an output pending; defaults afterwards are N=1, divide.
    configure(2, 1'b0, 1'b1);
    send(0, 5); send(0, 6); send(0, 7);
    dir_rdy = 1'b0;
    send(0, 8);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    dir_rdy = 1'b1;
    tick();
    clear_got();
    send(0, 77);
    drain();
    chk("rst_count", got_u_q.size(), 32'd1);
    chk("rst_pass", 32'(got_u_q[0]), 32'({2'd0, 16'd77}));

    // Out-of-range channel is swallowed without touching channel state.
    configure(1, 1'b0, 1'b1);
    clear_got();
    send(0, 50); send(3, 999); send(0, 70); send(2, 11); send(2, 13);
    drain();
    @(negedge clk);
    chk("cerr_set", 32'(cerr_u), 32'd1);
    chk("cerr_count", got_u_q.size(), 32'd2);
    chk("cerr_ch0", 32'(got_u_q[0]), 32'({2'd0, 16'd60}));
    chk("cerr_ch2", 32'(got_u_q[1]), 32'({2'd2, 16'd12}));
    tick();
    configure(1, 1'b0, 1'b1);
    @(negedge clk);
    chk("cerr_cleared", 32'(cerr_u), 32'd0);
    tick();

    // Randomised configurations, channels, data and downstream stalls.
    rand_rdy = 1'b1;
    for (int r = 0; r < 12; r++) begin
      configure($urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 80; i++) begin
        send(($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2), $urandom_range(0, 4095));
      end
    end
    rand_rdy = 1'b0;
    dir_rdy  = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
